// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
// Shared encodings for the pong game blocks: match state codes, winner codes
// and the serve direction bit. The paddle and ball blocks import the same
// definitions, so every block decodes these values the same way.
// -----------------------------------------------------------------------------
package pong_pkg;

  // Match sequencer states. Codes 5..7 are unused and recover to ST_IDLE.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_A    = 2'b01,
    WIN_B    = 2'b10
  } winner_e;

  // serve_dir encoding: the ball is launched toward this player.
  localparam logic SERVE_TO_A = 1'b0;
  localparam logic SERVE_TO_B = 1'b1;

endpackage : pong_pkg

// File: rtl/pong_match_ctrl_if.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl_if
// Signal bundle between the match sequencer and its surroundings.
//   master : button/debounce layer and ball block side; drives start, miss_a,
//            miss_b and observes the sequencer outputs.
//   slave  : the match sequencer itself.
// Signals:
//   start            debounced start button (level)
//   miss_a, miss_b   ball passed the player's row without paddle contact
//   tick             one-cycle game-step strobe
//   paddle_en        enable of both paddle blocks (low recentres them)
//   ball_en          ball may move on tick
//   ball_load        one-cycle pulse: ball loads centre position and serve_dir
//   serve_dir        0 = serve toward A, 1 = toward B
//   score_a/score_b  current points
//   winner           00 none, 01 A, 10 B
//   state            current state code (debug/display)
// -----------------------------------------------------------------------------
interface pong_match_ctrl_if #(
  parameter int SCORE_W = 3
);
  logic               start;
  logic               miss_a;
  logic               miss_b;
  logic               tick;
  logic               paddle_en;
  logic               ball_en;
  logic               ball_load;
  logic               serve_dir;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic [1:0]         winner;
  logic [2:0]         state;

  modport master (
    output start, miss_a, miss_b,
    input  tick, paddle_en, ball_en, ball_load, serve_dir,
           score_a, score_b, winner, state
  );

  modport slave (
    input  start, miss_a, miss_b,
    output tick, paddle_en, ball_en, ball_load, serve_dir,
           score_a, score_b, winner, state
  );
endinterface : pong_match_ctrl_if

// File: rtl/pong_tick_gen.sv
// -----------------------------------------------------------------------------
// pong_tick_gen
// Free-running game-step divider. The count runs 0..TICK_DIV-1 and tick is
// high for the single cycle in which the count equals TICK_DIV-1, giving a
// period of exactly TICK_DIV cycles; the first tick after reset falls in
// cycle TICK_DIV-1.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   tick   registered one-cycle strobe
// -----------------------------------------------------------------------------
module pong_tick_gen #(
  parameter int TICK_DIV = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int                CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    // Registering the decode of the next count keeps tick aligned with the
    // cycle in which the count equals LAST, without a decode on the output.
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : pong_tick_gen

// File: rtl/pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// pong_match_ctrl
// Match sequencer for two-player pong. Owns the match FSM and the step tick,
// drives the paddle and ball enables, counts points from the ball block's miss
// reports and declares a winner.
// Ports:
//   clk    system clock, all logic on posedge
//   rst_n  synchronous active-low reset
//   bus    pong_match_ctrl_if.slave (start/miss inputs, all game outputs)
// Inputs are captured in a register stage before the FSM acts on them, so a
// start or miss sampled at edge n takes effect on the outputs after edge n+1.
// Every output is driven straight from a flop.
// -----------------------------------------------------------------------------
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV   = 8,
  parameter int WIN_SCORE  = 5,
  parameter int SCORE_W    = 3,
  parameter int POINT_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pong_match_ctrl_if.slave  bus
);

  localparam int                  HOLD_W = $clog2(POINT_HOLD + 1);
  localparam logic [SCORE_W-1:0] WIN_PTS = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_N  = HOLD_W'(POINT_HOLD);

  logic tick;

  pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  state_e             state_q,     state_d;
  logic               start_s_q,   start_s_d;   // input capture of start
  logic               start_q,     start_d;     // previous captured start
  logic               miss_a_q,    miss_a_d;
  logic               miss_b_q,    miss_b_d;
  logic [HOLD_W-1:0]  hold_q,      hold_d;
  logic [SCORE_W-1:0] score_a_q,   score_a_d;
  logic [SCORE_W-1:0] score_b_q,   score_b_d;
  winner_e            winner_q,    winner_d;
  logic               serve_dir_q, serve_dir_d;
  logic               paddle_en_q, paddle_en_d;
  logic               ball_en_q,   ball_en_d;
  logic               ball_load_q, ball_load_d;

  logic               start_edge;
  logic [SCORE_W-1:0] score_a_inc, score_b_inc;

  assign start_edge  = start_s_q & ~start_q;
  assign score_a_inc = score_a_q + SCORE_W'(1);
  assign score_b_inc = score_b_q + SCORE_W'(1);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    start_s_d   = bus.start;
    start_d     = start_s_q;
    miss_a_d    = bus.miss_a;
    miss_b_d    = bus.miss_b;
    state_d     = state_q;
    hold_d      = '0;
    score_a_d   = score_a_q;
    score_b_d   = score_b_q;
    winner_d    = winner_q;
    serve_dir_d = serve_dir_q;

    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d     = ST_SERVE;
          score_a_d   = '0;
          score_b_d   = '0;
          winner_d    = WIN_NONE;
          serve_dir_d = SERVE_TO_A;
        end
      end

      ST_SERVE: begin
        if (tick) state_d = ST_PLAY;
      end

      ST_PLAY: begin
        if (miss_a_q && miss_b_q) begin
          // Double miss: nobody scores, re-serve the other way.
          serve_dir_d = ~serve_dir_q;
          state_d     = ST_SERVE;
        end else if (miss_a_q) begin
          score_b_d   = score_b_inc;
          serve_dir_d = SERVE_TO_A;
          if (score_b_inc == WIN_PTS) begin
            state_d  = ST_OVER;
            winner_d = WIN_B;
          end else begin
            state_d  = ST_POINT;
          end
        end else if (miss_b_q) begin
          score_a_d   = score_a_inc;
          serve_dir_d = SERVE_TO_B;
          if (score_a_inc == WIN_PTS) begin
            state_d  = ST_OVER;
            winner_d = WIN_A;
          end else begin
            state_d  = ST_POINT;
          end
        end
      end

      ST_POINT: begin
        // hold_q is zero on entry because the default clears it in every
        // other state; only ticks seen while already in POINT count.
        hold_d = hold_q;
        if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_d == HOLD_N) state_d = ST_SERVE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Enables follow the state being entered so they are registered
    // alongside it and line up with the state output.
    ball_load_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    paddle_en_d = (state_d == ST_SERVE) || (state_d == ST_PLAY);
    ball_en_d   = (state_d == ST_PLAY);
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // updates use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      start_s_q   <= 1'b0;
      start_q     <= 1'b0;
      miss_a_q    <= 1'b0;
      miss_b_q    <= 1'b0;
      hold_q      <= '0;
      score_a_q   <= '0;
      score_b_q   <= '0;
      winner_q    <= WIN_NONE;
      serve_dir_q <= SERVE_TO_A;
      paddle_en_q <= 1'b0;
      ball_en_q   <= 1'b0;
      ball_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_s_q   <= start_s_d;
      start_q     <= start_d;
      miss_a_q    <= miss_a_d;
      miss_b_q    <= miss_b_d;
      hold_q      <= hold_d;
      score_a_q   <= score_a_d;
      score_b_q   <= score_b_d;
      winner_q    <= winner_d;
      serve_dir_q <= serve_dir_d;
      paddle_en_q <= paddle_en_d;
      ball_en_q   <= ball_en_d;
      ball_load_q <= ball_load_d;
    end
  end

  assign bus.tick      = tick;
  assign bus.paddle_en = paddle_en_q;
  assign bus.ball_en   = ball_en_q;
  assign bus.ball_load = ball_load_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.score_a   = score_a_q;
  assign bus.score_b   = score_b_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule : pong_match_ctrl

// File: tb/tb_pong_match_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pong_match_ctrl
// Directed bench for pong_match_ctrl with TICK_DIV=8, WIN_SCORE=5, SCORE_W=3,
// POINT_HOLD=4. Cycle numbers in comments count from the last reset edge
// (cycle 0); ticks fall in cycles where cycle % 8 == 7.
// -----------------------------------------------------------------------------
module tb_pong_match_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pong_match_ctrl_if #(.SCORE_W(3)) bus ();

  pong_match_ctrl #(
    .TICK_DIV   (8),
    .WIN_SCORE  (5),
    .SCORE_W    (3),
    .POINT_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges; sample 1 time unit after the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step until the state matches, giving up after budget cycles.
  task automatic wait_state(input logic [2:0] target, input int budget,
                            input string tag);
    int n;
    n = 0;
    while (bus.state !== target && n < budget) begin
      step(1);
      n++;
    end
    check(tag, {29'd0, bus.state}, {29'd0, target});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},     {29'd0, bus.state},  32'd0);
    check({tag, "_tick"},      {31'd0, bus.tick},   32'd0);
    check({tag, "_paddle_en"}, {31'd0, bus.paddle_en}, 32'd0);
    check({tag, "_ball_en"},   {31'd0, bus.ball_en},   32'd0);
    check({tag, "_ball_load"}, {31'd0, bus.ball_load}, 32'd0);
    check({tag, "_serve_dir"}, {31'd0, bus.serve_dir}, 32'd0);
    check({tag, "_score_a"},   {29'd0, bus.score_a},   32'd0);
    check({tag, "_score_b"},   {29'd0, bus.score_b},   32'd0);
    check({tag, "_winner"},    {30'd0, bus.winner},    32'd0);
  endtask

  initial begin
    logic [4:0] a_scores_seq;
    checks = 0;
    errors = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.miss_a = 1'b0;
    bus.miss_b = 1'b0;

    // ---- reset / idle ----
    step(3);                       // cycle 0
    check_reset_values("rst");
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check($sformatf("tick_c%0d", i), {31'd0, bus.tick}, (i == 7) ? 32'd1 : 32'd0);
    end
    step(1);                       // cycle 8
    check("tick_c8", {31'd0, bus.tick}, 32'd0);
    check("idle_state", {29'd0, bus.state}, 32'd0);

    // ---- serve ----
    bus.start = 1'b1;
    step(1);                       // cycle 9: start captured, not yet acted on
    bus.start = 1'b0;
    check("start_lat_state", {29'd0, bus.state}, 32'd0);
    step(1);                       // cycle 10
    check("serve_state",     {29'd0, bus.state}, 32'd1);
    check("serve_load",      {31'd0, bus.ball_load}, 32'd1);
    check("serve_paddle_en", {31'd0, bus.paddle_en}, 32'd1);
    check("serve_ball_en",   {31'd0, bus.ball_en}, 32'd0);
    step(1);                       // cycle 11
    check("serve_load_off",  {31'd0, bus.ball_load}, 32'd0);
    step(4);                       // cycle 15
    check("serve_hold_state", {29'd0, bus.state}, 32'd1);
    check("serve_tick",       {31'd0, bus.tick}, 32'd1);
    step(1);                       // cycle 16
    check("play_state",     {29'd0, bus.state}, 32'd2);
    check("play_paddle_en", {31'd0, bus.paddle_en}, 32'd1);
    check("play_ball_en",   {31'd0, bus.ball_en}, 32'd1);

    // ---- single miss_b: A scores ----
    bus.miss_b = 1'b1;
    step(1);                       // cycle 17
    bus.miss_b = 1'b0;
    check("miss_lat_state", {29'd0, bus.state}, 32'd2);
    step(1);                       // cycle 18
    check("pt_score_a",   {29'd0, bus.score_a}, 32'd1);
    check("pt_score_b",   {29'd0, bus.score_b}, 32'd0);
    check("pt_serve_dir", {31'd0, bus.serve_dir}, 32'd1);
    check("pt_state",     {29'd0, bus.state}, 32'd3);
    check("pt_paddle_en", {31'd0, bus.paddle_en}, 32'd0);
    check("pt_ball_en",   {31'd0, bus.ball_en}, 32'd0);
    step(29);                      // cycle 47: fourth tick after entry
    check("pt_hold_state", {29'd0, bus.state}, 32'd3);
    check("pt_hold_tick",  {31'd0, bus.tick}, 32'd1);
    step(1);                       // cycle 48
    check("reserve_state", {29'd0, bus.state}, 32'd1);
    check("reserve_load",  {31'd0, bus.ball_load}, 32'd1);
    check("reserve_dir",   {31'd0, bus.serve_dir}, 32'd1);
    step(8);                       // cycle 56 (tick at 55)
    check("replay_state",  {29'd0, bus.state}, 32'd2);

    // ---- simultaneous miss ----
    bus.miss_a = 1'b1;
    bus.miss_b = 1'b1;
    step(1);                       // cycle 57
    bus.miss_a = 1'b0;
    bus.miss_b = 1'b0;
    step(1);                       // cycle 58
    check("dbl_state",   {29'd0, bus.state}, 32'd1);
    check("dbl_score_a", {29'd0, bus.score_a}, 32'd1);
    check("dbl_score_b", {29'd0, bus.score_b}, 32'd0);
    check("dbl_dir",     {31'd0, bus.serve_dir}, 32'd0);
    check("dbl_load",    {31'd0, bus.ball_load}, 32'd1);
    step(6);                       // cycle 64 (tick at 63)
    check("dbl_play", {29'd0, bus.state}, 32'd2);

    // ---- five miss_a points: B wins; each point spans 40 cycles ----
    for (int pt = 1; pt <= 5; pt++) begin
      if (pt == 5) bus.start = 1'b1;  // rises during PLAY: must be ignored
      bus.miss_a = 1'b1;
      step(1);
      bus.miss_a = 1'b0;
      step(1);
      check($sformatf("win_p%0d_score_b", pt), {29'd0, bus.score_b}, 32'(pt));
      check($sformatf("win_p%0d_dir", pt), {31'd0, bus.serve_dir}, 32'd0);
      if (pt < 5) begin
        check($sformatf("win_p%0d_point", pt), {29'd0, bus.state}, 32'd3);
        step(30);
        check($sformatf("win_p%0d_serve", pt), {29'd0, bus.state}, 32'd1);
        step(8);
        check($sformatf("win_p%0d_play", pt), {29'd0, bus.state}, 32'd2);
      end
    end
    check("over_state",     {29'd0, bus.state}, 32'd4);
    check("over_winner",    {30'd0, bus.winner}, 32'd2);
    check("over_score_a",   {29'd0, bus.score_a}, 32'd1);
    check("over_paddle_en", {31'd0, bus.paddle_en}, 32'd0);
    check("over_ball_en",   {31'd0, bus.ball_en}, 32'd0);

    // Misses and a held start level change nothing in OVER.
    bus.miss_a = 1'b1;
    bus.miss_b = 1'b1;
    step(3);
    bus.miss_a = 1'b0;
    bus.miss_b = 1'b0;
    step(2);
    check("hold_state",   {29'd0, bus.state}, 32'd4);
    check("hold_score_a", {29'd0, bus.score_a}, 32'd1);
    check("hold_score_b", {29'd0, bus.score_b}, 32'd5);
    check("hold_winner",  {30'd0, bus.winner}, 32'd2);

    // New start edge restarts at 0-0.
    bus.start = 1'b0;
    step(2);
    bus.start = 1'b1;
    step(1);
    bus.start = 1'b0;
    check("restart_lat", {29'd0, bus.state}, 32'd4);
    step(1);
    check("restart_state",   {29'd0, bus.state}, 32'd1);
    check("restart_load",    {31'd0, bus.ball_load}, 32'd1);
    check("restart_score_a", {29'd0, bus.score_a}, 32'd0);
    check("restart_score_b", {29'd0, bus.score_b}, 32'd0);
    check("restart_winner",  {30'd0, bus.winner}, 32'd0);
    check("restart_dir",     {31'd0, bus.serve_dir}, 32'd0);
    wait_state(3'd2, 16, "restart_play");

    // ---- build 3-2, then reset mid-PLAY ----
    a_scores_seq = 5'b10101;       // bit i set: miss_b, so A scores
    for (int i = 0; i < 5; i++) begin
      if (a_scores_seq[i]) bus.miss_b = 1'b1;
      else                 bus.miss_a = 1'b1;
      step(1);
      bus.miss_a = 1'b0;
      bus.miss_b = 1'b0;
      step(1);
      check($sformatf("seq%0d_point", i), {29'd0, bus.state}, 32'd3);
      wait_state(3'd2, 48, $sformatf("seq%0d_play", i));
    end
    check("pre_rst_score_a", {29'd0, bus.score_a}, 32'd3);
    check("pre_rst_score_b", {29'd0, bus.score_b}, 32'd2);

    bus.miss_a = 1'b1;
    rst_n = 1'b0;
    step(1);
    check_reset_values("midrst");
    bus.miss_a = 1'b0;
    rst_n = 1'b1;                  // this cycle is cycle 0 again
    for (int i = 1; i <= 7; i++) begin
      step(1);
      check($sformatf("rtick_c%0d", i), {31'd0, bus.tick}, (i == 7) ? 32'd1 : 32'd0);
    end
    check("post_rst_state", {29'd0, bus.state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_pong_match_ctrl
